rcb_arb: RTL
============

// Module: rcb_arb
// PURPOSE
//  Next-generation RAM control block: multi-channel symbol-lookup reads plus buffered host
//  writes to one single-port per-symbol parameter RAM. Sits between feed decoder(s) and the
//  strategy comparators. Adds: N read channels, write queue with valid/ready handshake,
//  write anti-starvation, drop flags and drop counter. Host path no longer holds a sticky req.
// PARAMETERS
//  ADDR_W      14  RAM address width; depth = 2**ADDR_W
//  DATA_W      64  RAM word width; multiple of 8
//  NUM_RD       2  number of feed read channels (1..4)
//  WQ_DEPTH     4  write queue entries; power of 2, >=2
//  STARVE_MAX   8  consecutive cycles a pending write may lose before it is forced
// PORTS
//  clk           in   1              core clock
//  reset_n       in   1              async active-low reset
//  rd_req        in   NUM_RD         per-channel read strobe
//  rd_addr       in   NUM_RD*ADDR_W  per-channel read address, ch i at [i*ADDR_W +: ADDR_W]
//  rd_vld        out  NUM_RD         read data valid, 1 cycle after granted rd_req
//  rd_data       out  NUM_RD*DATA_W  registered read data, held until next rd_vld on channel
//  rd_drop       out  NUM_RD         pulse: that channel's rd_req was not serviced
//  drop_cnt      out  16             saturating count of dropped reads (all channels)
//  wr_valid      in   1              host write request
//  wr_ready      out  1              queue not full; write accepted when wr_valid&&wr_ready
//  wr_addr       in   ADDR_W         host write address
//  wr_data       in   DATA_W         host write data
//  wr_be         in   DATA_W/8       byte enables, bit i -> byte i
//  wr_done       out  1              pulse 1 cycle after a queued write commits to RAM
//  wq_level      out  $clog2(WQ_DEPTH)+1  queue occupancy
//  rd_perr       out  NUM_RD         parity error with rd_vld (RCB_PARITY_EN only)
// BEHAVIOUR
//  - Reset: queue empty, starve cnt 0, drop_cnt 0, rd_vld/rd_drop/wr_done/rd_perr 0,
//    rd_data 0, wr_ready 1. RAM contents not reset. Reset mid-operation discards queued
//    writes with no wr_done; a write committing in the reset cycle is not guaranteed.
//  - One RAM access per cycle. Arbitration each cycle:
//    1. starve_cnt==STARVE_MAX and queue non-empty -> head write granted (forced);
//    2. else lowest-index asserted rd_req granted;
//    3. else head write granted if queue non-empty.
//  - Ungranted rd_req in a cycle -> rd_drop[i] pulses next cycle (aligned with winner's
//    rd_vld); drop_cnt += number of drops that cycle, saturating at 16'hFFFF.
//  - starve_cnt: +1 per cycle queue non-empty and write not granted; cleared on write grant
//    or queue empty. Never exceeds STARVE_MAX.
//  - Read latency 1: RAM output registered into rd_data slice of granted channel only.
//  - Write: byte-masked per wr_be; wr_be==0 still commits (no-op) and pulses wr_done.
//  - Queue is FIFO; push and pop same cycle allowed, level unchanged. Full: wr_ready=0,
//    push ignored. wr_ready is registered-free: !full, combinational from level only.
//  - Hazard: read to an address with a pending queued write returns pre-write RAM data.
//    Read and write never share a cycle, so no same-address collision exists.
//  - wq_level updates the cycle after push/pop.
// CONFIGURATION
//  RCB_PARITY_EN defined: RAM widened by DATA_W/8 bits, one even-parity bit per byte,
//   written from wr_data per enabled byte; on read rd_perr[i] = any byte parity mismatch,
//   asserted with rd_vld[i]. Undefined: no extra RAM bits, rd_perr tied 0.
// TESTING
//  1. Reset, write addr 0x0010 data 0x0123456789ABCDEF be 0xFF, then rd_req[0] addr
//     0x0010 -> wr_done 1 cycle after commit; rd_vld[0] next cycle, rd_data[0] = written.
//  2. Partial write be=0x0F data all 0xFF over 0 -> read returns 0x00000000FFFFFFFF.
//  3. rd_req=2'b11 same cycle -> ch0 rd_vld, rd_drop[1]=1, drop_cnt=1; repeat 0x10000 ->
//     drop_cnt holds 0xFFFF.
//  4. Continuous rd_req[0] with 1 queued write -> write forced on 9th cycle, rd_drop[0]
//     that cycle, wr_done follows; starve_cnt back to 0.
//  5. Push 5 writes, no pops (reads saturate) -> wr_ready=0 after 4, wq_level=4, 5th
//     ignored; release reads -> 4 wr_done pulses in order.
//  6. RCB_PARITY_EN: force-flip one stored bit at addr 0x0020 -> read gives rd_perr=1;
//     clean address gives rd_perr=0. Assert reset_n mid-queue -> wq_level=0, no wr_done.

Source files
------------

// File: rtl/rcb_arb_if.sv
// Host/feed-side bundle for rcb_arb: read channels, write queue handshake and status.
// slave = the arbiter's view, master = the feed decoder / host view.
interface rcb_arb_if #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned WQ_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(WQ_DEPTH) + 1;

    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_vld;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_drop;
    logic [15:0]              drop_cnt;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W/8-1:0]      wr_be;
    logic                     wr_done;
    logic [LVL_W-1:0]         wq_level;
    logic [NUM_RD-1:0]        rd_perr;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
        output rd_vld, rd_data, rd_drop, drop_cnt, wr_ready, wr_done, wq_level, rd_perr
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
        input  rd_vld, rd_data, rd_drop, drop_cnt, wr_ready, wr_done, wq_level, rd_perr
    );
endinterface

// File: rtl/rcb_arb.sv
// rcb_arb: N-channel read / queued host write arbiter in front of one single-port RAM.
// Define RCB_PARITY_EN to store and check one even-parity bit per data byte.
module rcb_arb #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned WQ_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic      clk,
    input logic      reset_n,
    rcb_arb_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned CH_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RCB_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + BE_W;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];
    logic [BE_W-1:0]   wq_be   [WQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [16:0]      drop_sum;

    logic [NUM_RD-1:0]        rd_vld_q, rd_drop_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic                     wr_done_q;

    logic              q_empty, q_full, push, force_wr, wr_gnt, rd_any;
    logic [NUM_RD-1:0] rd_gnt, drop;
    logic [CH_W-1:0]   rd_idx;
    logic [MEM_W-1:0]  rd_word;

    assign q_empty      = (level_q == '0);
    assign q_full       = (level_q == LVL_W'(WQ_DEPTH));
    assign push         = bus.wr_valid && !q_full;
    assign force_wr     = (starve_q == ST_W'(STARVE_MAX)) && !q_empty;
    assign bus.wr_ready = !q_full;

    // Priority: starved write, then lowest-index read, then any queued write.
    always_comb begin
        rd_gnt = '0;
        rd_idx = '0;
        rd_any = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (bus.rd_req[i] && !rd_any) begin
                rd_gnt[i] = 1'b1;
                rd_idx    = CH_W'(i);
                rd_any    = 1'b1;
            end
        end
        if (force_wr) begin
            rd_gnt = '0;
            rd_any = 1'b0;
        end
        wr_gnt = force_wr || (!rd_any && !q_empty);
        drop   = bus.rd_req & ~rd_gnt;
    end

    always_comb begin
        starve_d = starve_q;
        if (wr_gnt || q_empty) begin
            starve_d = '0;
        end else if (starve_q != ST_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(wr_gnt);
        level_d  = level_q + LVL_W'(push) - LVL_W'(wr_gnt);
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < int'(NUM_RD); i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign rd_word = mem[bus.rd_addr[rd_idx*ADDR_W +: ADDR_W]];

`ifdef RCB_PARITY_EN
    logic              rd_perr_bit;
    logic [NUM_RD-1:0] rd_perr_q;

    always_comb begin
        rd_perr_bit = 1'b0;
        for (int b = 0; b < int'(BE_W); b++) begin
            rd_perr_bit = rd_perr_bit | ((^rd_word[b*8 +: 8]) != rd_word[DATA_W+b]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_perr_q <= '0;
        end else begin
            rd_perr_q <= rd_gnt & {NUM_RD{rd_perr_bit}};
        end
    end

    assign bus.rd_perr = rd_perr_q;
`else
    assign bus.rd_perr = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            starve_q   <= '0;
            drop_cnt_q <= '0;
            rd_vld_q   <= '0;
            rd_drop_q  <= '0;
            rd_data_q  <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            starve_q   <= starve_d;
            drop_cnt_q <= drop_cnt_d;
            rd_vld_q   <= rd_gnt;
            rd_drop_q  <= drop;
            wr_done_q  <= wr_gnt;
            if (rd_any) begin
                rd_data_q[rd_idx*DATA_W +: DATA_W] <= rd_word[DATA_W-1:0];
            end
        end
    end

    // Queue payload and RAM array carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            wq_addr[wr_ptr_q] <= bus.wr_addr;
            wq_data[wr_ptr_q] <= bus.wr_data;
            wq_be[wr_ptr_q]   <= bus.wr_be;
        end
        if (wr_gnt) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wq_be[rd_ptr_q][b]) begin
                    mem[wq_addr[rd_ptr_q]][b*8 +: 8] <= wq_data[rd_ptr_q][b*8 +: 8];
`ifdef RCB_PARITY_EN
                    mem[wq_addr[rd_ptr_q]][DATA_W+b] <= ^wq_data[rd_ptr_q][b*8 +: 8];
`endif
                end
            end
        end
    end

    assign bus.rd_vld   = rd_vld_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_drop  = rd_drop_q;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.wq_level = level_q;
endmodule
